arkanoid_psg_mixer: RTL

- Upstream neighbour of the Arkanoid YM2149 low-pass filter.
- Takes the three unsigned per-channel PSG levels and sums them at a fixed sample rate (clk/DIV, 187.5 kHz at 12 MHz with DIV=64, matching the LPF sample rate).
- Scales the sum, removes DC with a first-order leaky-integrator blocker, saturates, and presents a signed 16-bit sample plus a one-cycle strobe.
- Summation is time-multiplexed over a small FSM so a single adder serves all three channels.

---
 rtl/arkanoid_psg_mixer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/arkanoid_psg_mixer.sv
// Arkanoid PSG mixer: sums the three YM2149 channel levels once per sample
// period, scales, DC-blocks, saturates and emits a signed 16-bit sample.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   ch_a/b/c   unsigned 8-bit channel levels
//   ch_en      channel enable mask (bit0=A, bit1=B, bit2=C)
//   dc_en      1 = DC blocker active, 0 = bypass
//   out        signed 16-bit sample, held between strobes
//   sample_stb one-clock pulse when out updates
module arkanoid_psg_mixer #(
  parameter int DIV        = 64,
  parameter int GAIN_SHIFT = 5,
  parameter int DC_SHIFT   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         ch_a,
  input  logic [7:0]         ch_b,
  input  logic [7:0]         ch_c,
  input  logic [2:0]         ch_en,
  input  logic               dc_en,
  output logic signed [15:0] out,
  output logic               sample_stb
);

  localparam int ACC_W = 16 + DC_SHIFT;
  localparam logic [9:0] LAST = 10'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD_A,
    S_ADD_B,
    S_ADD_C,
    S_OUTP
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          div_cnt_q, div_cnt_d;
  logic [7:0]          snap_a_q, snap_a_d;
  logic [7:0]          snap_b_q, snap_b_d;
  logic [7:0]          snap_c_q, snap_c_d;
  logic [9:0]          acc_q, acc_d;
  logic                dc_en_q, dc_en_d;
  logic [ACC_W-1:0]    dc_acc_q, dc_acc_d;
  logic signed [15:0]  out_q, out_d;
  logic                stb_q, stb_d;

  logic                start;
  logic [7:0]          addend;
  logic [17:0]         scaled;
  logic [15:0]         dc_est;
  logic signed [18:0]  diff;
  logic signed [15:0]  sat;

  assign start = (div_cnt_q == LAST);
  assign div_cnt_d = start ? 10'd0 : div_cnt_q + 10'd1;

  // Single shared adder: operand chosen by the FSM state.
  always_comb begin
    addend = 8'd0;
    unique case (state_q)
      S_ADD_A: addend = snap_a_q;
      S_ADD_B: addend = snap_b_q;
      S_ADD_C: addend = snap_c_q;
      default: addend = 8'd0;
    endcase
  end

  assign scaled = {8'd0, acc_q} << GAIN_SHIFT;
  assign dc_est = dc_en_q ? 16'(dc_acc_q >> DC_SHIFT) : 16'd0;
  assign diff   = $signed({1'b0, scaled}) - $signed({3'b000, dc_est});

  always_comb begin
    sat = diff[15:0];
    if (diff > 19'sd32767) begin
      sat = 16'sh7fff;
    end else if (diff < -19'sd32768) begin
      sat = 16'sh8000;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    snap_c_d = snap_c_q;
    acc_d    = acc_q;
    dc_en_d  = dc_en_q;
    dc_acc_d = dc_acc_q;
    out_d    = out_q;
    stb_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_a_d = ch_en[0] ? ch_a : 8'd0;
          snap_b_d = ch_en[1] ? ch_b : 8'd0;
          snap_c_d = ch_en[2] ? ch_c : 8'd0;
          acc_d    = 10'd0;
          dc_en_d  = dc_en;
          state_d  = S_ADD_A;
        end
      end
      S_ADD_A: begin
        acc_d   = acc_q + {2'b00, addend};
        state_d = S_ADD_B;
      end
      S_ADD_B: begin
        acc_d   = acc_q + {2'b00, addend};
        state_d = S_ADD_C;
      end
      S_ADD_C: begin
        acc_d   = acc_q + {2'b00, addend};
        state_d = S_OUTP;
      end
      S_OUTP: begin
        out_d = sat;
        stb_d = 1'b1;
        // Leaky integrator: dc_acc tracks the mean scaled by 2^DC_SHIFT.
        if (dc_en_q) begin
          dc_acc_d = dc_acc_q + {{(ACC_W-19){diff[18]}}, diff};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 10'd0;
      snap_a_q  <= 8'd0;
      snap_b_q  <= 8'd0;
      snap_c_q  <= 8'd0;
      acc_q     <= 10'd0;
      dc_en_q   <= 1'b0;
      dc_acc_q  <= '0;
      out_q     <= 16'sd0;
      stb_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      snap_c_q  <= snap_c_d;
      acc_q     <= acc_d;
      dc_en_q   <= dc_en_d;
      dc_acc_q  <= dc_acc_d;
      out_q     <= out_d;
      stb_q     <= stb_d;
    end
  end

  assign out        = out_q;
  assign sample_stb = stb_q;

endmodule
